// File: rtl/uart_pkg.sv
// Shared types, encodings and helpers for the buffered UART transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        EVEN = 2'b01,
        ODD  = 2'b10
    } parity_e;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    // cfg_data_bits encodings
    localparam logic [1:0] DBITS_5 = 2'b00;
    localparam logic [1:0] DBITS_6 = 2'b01;
    localparam logic [1:0] DBITS_7 = 2'b10;
    localparam logic [1:0] DBITS_8 = 2'b11;

    // Bit period in clock cycles, rounded to nearest.
    function automatic int baud_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    // Index of the last data bit sent for a given width encoding.
    function automatic logic [2:0] last_bit_index(input logic [1:0] cfg);
        case (cfg)
            DBITS_5: return 3'd4;
            DBITS_6: return 3'd5;
            DBITS_7: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

    // The spare encoding 11 also means no parity.
    function automatic parity_e parity_decode(input logic [1:0] cfg);
        case (cfg)
            2'b01:   return EVEN;
            2'b10:   return ODD;
            default: return NONE;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is dropped even if a pop
// happens in the same cycle.
module uart_fifo #(
    parameter  int DEPTH = 8,
    parameter  int WIDTH = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("uart_fifo: DEPTH must be a power of two and at least 2");
    end

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Storage array; contents are only meaningful behind the occupancy count.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO in front of a frame serialiser with run-time
// data width, parity and stop-bit selection; baud rate fixed at elaboration.
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             tx_valid,
    input  logic [7:0]                       tx_data,
    output logic                             tx_ready,
    input  logic [1:0]                       cfg_data_bits,
    input  logic [1:0]                       cfg_parity,
    input  logic                             cfg_stop2,
    output logic                             txd,
    output logic                             busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]  fifo_count
);

    localparam int DIV   = baud_div(CLK_HZ, BAUD);
    localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

    if (DIV < 2) begin : g_div_check
        $error("uart_tx_fifo: bit period must be at least 2 clock cycles");
    end

    tx_state_e        state, state_next;
    logic [CNT_W-1:0] baud_cnt, baud_cnt_next;
    logic [2:0]       bit_cnt, bit_cnt_next;
    logic [7:0]       shift, shift_next;
    logic             par_acc, par_acc_next;
    logic [2:0]       last_bit, last_bit_next;
    parity_e          par_mode, par_mode_next;
    logic             stop2, stop2_next;
    logic             txd_next;
    logic             load;
    logic             bit_end;
    logic             fifo_full;
    logic             fifo_empty;
    logic [7:0]       fifo_dout;

    uart_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_valid),
        .pop   (load),
        .din   (tx_data),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tx_ready = !fifo_full;
    assign busy     = (state != IDLE) || !fifo_empty;
    assign bit_end  = (baud_cnt == CNT_W'(DIV - 1));

    // Next-state logic; a frame load pops the FIFO head and snapshots the config.
    always_comb begin
        state_next    = state;
        baud_cnt_next = bit_end ? '0 : baud_cnt + 1'b1;
        bit_cnt_next  = bit_cnt;
        shift_next    = shift;
        par_acc_next  = par_acc;
        last_bit_next = last_bit;
        par_mode_next = par_mode;
        stop2_next    = stop2;
        load          = 1'b0;

        case (state)
            IDLE: begin
                baud_cnt_next = '0;
                if (!fifo_empty) load = 1'b1;
            end
            START: begin
                if (bit_end) state_next = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    par_acc_next = par_acc ^ shift[0];
                    shift_next   = shift >> 1;
                    if (bit_cnt == last_bit) begin
                        bit_cnt_next = '0;
                        state_next   = (par_mode == NONE) ? STOP : PARITY;
                    end else begin
                        bit_cnt_next = bit_cnt + 1'b1;
                    end
                end
            end
            PARITY: begin
                if (bit_end) state_next = STOP;
            end
            STOP: begin
                if (bit_end) begin
                    if (stop2 && bit_cnt == 3'd0) bit_cnt_next = 3'd1;
                    else if (!fifo_empty)         load = 1'b1;
                    else                          state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        if (load) begin
            state_next    = START;
            baud_cnt_next = '0;
            bit_cnt_next  = '0;
            shift_next    = fifo_dout;
            last_bit_next = last_bit_index(cfg_data_bits);
            par_mode_next = parity_decode(cfg_parity);
            par_acc_next  = (parity_decode(cfg_parity) == ODD);
            stop2_next    = cfg_stop2;
        end
    end

    // Line level for the coming cycle, so txd can be driven from a flop.
    always_comb begin
        txd_next = 1'b1;
        case (state_next)
            IDLE:    txd_next = 1'b1;
            START:   txd_next = 1'b0;
            DATA:    txd_next = shift_next[0];
            PARITY:  txd_next = par_acc_next;
            STOP:    txd_next = 1'b1;
            default: txd_next = 1'b1;
        endcase
    end

    // Control registers; reset abandons any frame and idles the line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            txd      <= 1'b1;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_cnt_next;
            bit_cnt  <= bit_cnt_next;
            txd      <= txd_next;
        end
    end

    // Frame data registers; always reloaded at frame start, so left unreset.
    always_ff @(posedge clk) begin
        shift    <= shift_next;
        par_acc  <= par_acc_next;
        last_bit <= last_bit_next;
        par_mode <= par_mode_next;
        stop2    <= stop2_next;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: stimulus queues hand-written line patterns,
// a monitor watches txd and checks every bit cycle-by-cycle.
module tb_uart_tx_fifo;

    localparam int DIV = 10;

    logic       clk;
    logic       reset;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic [1:0] cfg_data_bits;
    logic [1:0] cfg_parity;
    logic       cfg_stop2;
    logic       txd;
    logic       busy;
    logic [2:0] fifo_count;

    int checks = 0;
    int fails  = 0;
    bit abort  = 0;

    typedef struct {
        string bits;
        int    cnt;
        bit    b2b;
    } frame_t;

    frame_t sb[$];

    uart_tx_fifo #(
        .CLK_HZ     (1_000_000),
        .BAUD       (100_000),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .tx_valid      (tx_valid),
        .tx_data       (tx_data),
        .tx_ready      (tx_ready),
        .cfg_data_bits (cfg_data_bits),
        .cfg_parity    (cfg_parity),
        .cfg_stop2     (cfg_stop2),
        .txd           (txd),
        .busy          (busy),
        .fifo_count    (fifo_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: actual timeout, required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: actual %0d, required %0d", name, act, exp);
        end
    endtask

    task automatic expect_frame(input string bits, input int cnt, input bit b2b);
        frame_t f;
        f.bits = bits;
        f.cnt  = cnt;
        f.b2b  = b2b;
        sb.push_back(f);
    endtask

    // Called at a negedge; the push is sampled on the following posedge.
    task automatic push_byte(input logic [7:0] d);
        tx_valid = 1'b1;
        tx_data  = d;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic set_cfg(input logic [1:0] db, input logic [1:0] par, input logic s2);
        cfg_data_bits = db;
        cfg_parity    = par;
        cfg_stop2     = s2;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 3000);
    endtask

    // Monitor: detect start bits, pop the expected frame and compare bit by bit.
    initial begin : monitor
        frame_t f;
        logic   prev;
        logic   expv;
        bit     ok;
        bit     aborted;
        byte    ch;
        int     ncyc;
        int     last_end;
        int     fidx;
        ncyc     = 0;
        last_end = -100;
        fidx     = 0;
        do @(negedge clk); while (reset);
        prev = txd;
        forever begin
            @(negedge clk);
            ncyc++;
            if (!reset && prev === 1'b1 && txd === 1'b0) begin
                if (sb.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_frame: actual start bit at monitor cycle %0d, required none", ncyc);
                end else begin
                    f = sb.pop_front();
                    check($sformatf("frame%0d_fifo_count_at_start", fidx), int'(fifo_count), f.cnt);
                    if (f.b2b)
                        check($sformatf("frame%0d_b2b_gap", fidx), ncyc - last_end - 1, 0);
                    aborted = 1'b0;
                    for (int b = 0; b < f.bits.len() && !aborted; b++) begin
                        ch   = f.bits[b];
                        expv = (ch == "1");
                        ok   = 1'b1;
                        for (int c = 0; c < DIV; c++) begin
                            if (b != 0 || c != 0) begin
                                @(negedge clk);
                                ncyc++;
                            end
                            if (abort) begin
                                aborted = 1'b1;
                                break;
                            end
                            if (txd !== expv) ok = 1'b0;
                        end
                        if (!aborted)
                            check($sformatf("frame%0d_bit%0d_held_%0d_cycles_at_%0d", fidx, b, DIV, expv), int'(ok), 1);
                    end
                    last_end = ncyc;
                    fidx++;
                end
            end
            prev = txd;
        end
    end

    // Stimulus
    initial begin : stimulus
        int  n;
        int  exp_cnt[5];
        bit  saw_low;
        exp_cnt = '{1, 1, 2, 3, 4};

        reset    = 1'b1;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        set_cfg(2'b11, 2'b00, 1'b0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("reset_txd", int'(txd), 1);
        check("reset_tx_ready", int'(tx_ready), 1);
        check("reset_busy", int'(busy), 0);
        check("reset_fifo_count", int'(fifo_count), 0);

        // 8N1 0xA5: latency and frame length
        expect_frame("0101001011", 0, 1'b0);
        push_byte(8'hA5);
        check("a5_txd_after_write", int'(txd), 1);
        check("a5_count_after_write", int'(fifo_count), 1);
        @(negedge clk);
        check("a5_txd_after_pop", int'(txd), 0);
        check("a5_count_after_pop", int'(fifo_count), 0);
        wait_idle(n);
        check("a5_busy_cycles_after_start", n, 100);

        // 7E2 0x83: bit 7 ignored, even parity 0, two stop bits
        set_cfg(2'b10, 2'b01, 1'b1);
        expect_frame("01100000011", 0, 1'b0);
        push_byte(8'h83);
        wait_idle(n);
        check("7e2_busy_cycles", n, 111);

        // 5O1 0x1F: odd parity 0
        set_cfg(2'b00, 2'b10, 1'b0);
        expect_frame("01111101", 0, 1'b0);
        push_byte(8'h1F);
        wait_idle(n);
        check("5o1_busy_cycles", n, 81);

        // Six consecutive pushes into a depth-4 FIFO; sixth refused
        set_cfg(2'b11, 2'b00, 1'b0);
        expect_frame("0100000001", 1, 1'b0);
        expect_frame("0010000001", 3, 1'b1);
        expect_frame("0110000001", 2, 1'b1);
        expect_frame("0001000001", 1, 1'b1);
        expect_frame("0101000001", 0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            push_byte(8'(i + 1));
            check($sformatf("burst_count_after_push%0d", i + 1), int'(fifo_count), exp_cnt[i]);
        end
        check("burst_tx_ready_full", int'(tx_ready), 0);
        push_byte(8'h06);
        check("burst_count_after_refused", int'(fifo_count), 4);
        check("burst_tx_ready_still_full", int'(tx_ready), 0);
        wait_idle(n);
        check("burst_busy_cycles", n, 496);

        // Parity change mid-frame affects only the next frame
        set_cfg(2'b11, 2'b00, 1'b0);
        expect_frame("0001111001", 1, 1'b0);
        expect_frame("01110000011", 0, 1'b1);
        push_byte(8'h3C);
        push_byte(8'h07);
        repeat (24) @(negedge clk);
        cfg_parity = 2'b01;
        wait_idle(n);
        check("parity_change_busy_cycles", n, 186);
        cfg_parity = 2'b00;

        // Reset at cycle 35 of a frame with three bytes queued
        expect_frame("0100010001", 1, 1'b0);
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        check("abort_count_queued", int'(fifo_count), 3);
        repeat (32) @(negedge clk);
        reset = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_txd", int'(txd), 1);
        check("abort_fifo_count", int'(fifo_count), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_tx_ready", int'(tx_ready), 1);
        saw_low = 1'b0;
        repeat (300) begin
            @(negedge clk);
            if (txd !== 1'b1) saw_low = 1'b1;
        end
        check("abort_line_quiet", int'(saw_low), 0);
        abort = 1'b0;

        check("scoreboard_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
